// File: rtl/cl_ocl_regfile.sv
// AXI4-Lite style register file: NUM_RW read/write control registers with byte
// strobes and optional byte-swapped readback, plus NUM_RO read-only status slots.
module cl_ocl_regfile #(
  parameter int unsigned        NUM_RW      = 4,
  parameter int unsigned        NUM_RO      = 2,
  parameter logic [31:0]        BASE_ADDR   = 32'h0000_0500,
  parameter logic [NUM_RW-1:0]  SWAP_MASK   = NUM_RW'(1),
  parameter logic [31:0]        UNIMP_VALUE = 32'hDEAD_BEEF
) (
  input  logic                                    clk_main_a0,
  input  logic                                    rst_main_n,

  input  logic                                    awvalid,
  output logic                                    awready,
  input  logic [31:0]                             awaddr,

  input  logic                                    wvalid,
  output logic                                    wready,
  input  logic [31:0]                             wdata,
  input  logic [3:0]                              wstrb,

  output logic                                    bvalid,
  input  logic                                    bready,
  output logic [1:0]                              bresp,

  input  logic                                    arvalid,
  output logic                                    arready,
  input  logic [31:0]                             araddr,

  output logic                                    rvalid,
  input  logic                                    rready,
  output logic [31:0]                             rdata,
  output logic [1:0]                              rresp,

  output logic [NUM_RW*32-1:0]                    rw_q,
  output logic [NUM_RW-1:0]                       wr_pulse,
  input  logic [((NUM_RO > 0) ? NUM_RO : 1)*32-1:0] ro_in
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {SEL_NONE, SEL_RW, SEL_RO} sel_e;

  typedef struct packed {
    sel_e       sel;
    logic [4:0] idx;
  } dec_t;

  // Word index relative to BASE_ADDR; addresses below the base are unmapped.
  function automatic dec_t decode(input logic [31:0] addr);
    dec_t        d;
    logic [31:0] word;
    d.sel = SEL_NONE;
    d.idx = '0;
    word  = (addr - BASE_ADDR) >> 2;
    if (addr >= BASE_ADDR) begin
      if (word < 32'(NUM_RW)) begin
        d.sel = SEL_RW;
        d.idx = word[4:0];
      end else if (word < 32'(NUM_RW + NUM_RO)) begin
        d.sel = SEL_RO;
        d.idx = 5'(word - 32'(NUM_RW));
      end
    end
    return d;
  endfunction

  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  logic [31:0] rw_r [NUM_RW];

  logic        aw_held;
  logic [31:0] aw_addr_q;
  logic        w_held;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic        commit;
  dec_t        wdec;

  logic        ar_held;
  logic [31:0] ar_addr_q;
  dec_t        rdec;
  logic [31:0] rd_next;
  logic [1:0]  rresp_next;

  assign awready = !aw_held && !bvalid;
  assign wready  = !w_held && !bvalid;
  assign arready = !ar_held && !rvalid;

  assign commit = aw_held && w_held;
  assign wdec   = decode(aw_addr_q);
  assign rdec   = decode(ar_addr_q);

  for (genvar g = 0; g < NUM_RW; g++) begin : g_rw_out
    assign rw_q[32*g +: 32] = rw_r[g];
  end

  always_comb begin
    wr_pulse = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      wr_pulse[i] = commit && (wdec.sel == SEL_RW) && (wdec.idx == 5'(i));
    end
  end

  // Write channel: AW and W are captured independently and committed together
  // once both are held; bvalid blocks further acceptance until B completes.
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      aw_held   <= 1'b0;
      aw_addr_q <= '0;
      w_held    <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (awvalid && awready) begin
        aw_held   <= 1'b1;
        aw_addr_q <= awaddr;
      end
      if (wvalid && wready) begin
        w_held   <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= (wdec.sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
        bresp  <= RESP_OKAY;
      end
    end
  end

  // NOTE: the register array is reset explicitly because its contents drive
  // downstream control logic; a register file used as plain storage would not be.
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      for (int i = 0; i < NUM_RW; i++) rw_r[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_RW; i++) begin
        for (int k = 0; k < 4; k++) begin
          if (wr_pulse[i] && w_strb_q[k]) rw_r[i][8*k +: 8] <= w_data_q[8*k +: 8];
        end
      end
    end
  end

  // Read mux; rw_r still holds pre-commit data on the edge the response loads.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    rd_next    = UNIMP_VALUE;
    rresp_next = RESP_SLVERR;
    case (rdec.sel)
      SEL_RW: begin
        rresp_next = RESP_OKAY;
        for (int i = 0; i < NUM_RW; i++) begin
          if (rdec.idx == 5'(i)) rd_next = SWAP_MASK[i] ? byte_swap(rw_r[i]) : rw_r[i];
        end
      end
      SEL_RO: begin
        rresp_next = RESP_OKAY;
        for (int j = 0; j < NUM_RO; j++) begin
          if (rdec.idx == 5'(j)) rd_next = ro_in[32*j +: 32];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      ar_held   <= 1'b0;
      ar_addr_q <= '0;
      rvalid    <= 1'b0;
      rdata     <= '0;
      rresp     <= RESP_OKAY;
    end else if (arvalid && arready) begin
      ar_held   <= 1'b1;
      ar_addr_q <= araddr;
    end else if (ar_held) begin
      ar_held <= 1'b0;
      rvalid  <= 1'b1;
      rdata   <= rd_next;
      rresp   <= rresp_next;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end
  end

endmodule

// File: tb/tb_cl_ocl_regfile.sv
// Directed bench for cl_ocl_regfile: stimulus pushes expected B/R responses into
// queues, and an independent monitor pops and compares on every handshake.
module tb_cl_ocl_regfile;

  logic         clk_main_a0 = 1'b0;
  logic         rst_main_n  = 1'b0;
  logic         awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic         bready  = 1'b1, rready = 1'b1;
  logic [31:0]  awaddr  = '0, wdata = '0, araddr = '0;
  logic [3:0]   wstrb   = '0;
  logic         awready, wready, arready, bvalid, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [127:0] rw_q;
  logic [3:0]   wr_pulse;
  logic [63:0]  ro_in = '0;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_exp_t;

  logic [1:0] exp_b [$];
  r_exp_t     exp_r [$];

  cl_ocl_regfile dut (
    .clk_main_a0 (clk_main_a0),
    .rst_main_n  (rst_main_n),
    .awvalid     (awvalid),
    .awready     (awready),
    .awaddr      (awaddr),
    .wvalid      (wvalid),
    .wready      (wready),
    .wdata       (wdata),
    .wstrb       (wstrb),
    .bvalid      (bvalid),
    .bready      (bready),
    .bresp       (bresp),
    .arvalid     (arvalid),
    .arready     (arready),
    .araddr      (araddr),
    .rvalid      (rvalid),
    .rready      (rready),
    .rdata       (rdata),
    .rresp       (rresp),
    .rw_q        (rw_q),
    .wr_pulse    (wr_pulse),
    .ro_in       (ro_in)
  );

  always #5 clk_main_a0 = ~clk_main_a0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compare whenever a response handshake is seen.
  initial begin
    forever begin
      @(negedge clk_main_a0);
      if (bvalid && bready) begin
        if (exp_b.size() == 0) check("b_unexpected", 1, 0);
        else check("bresp", {126'b0, bresp}, {126'b0, exp_b.pop_front()});
      end
      if (rvalid && rready) begin
        if (exp_r.size() == 0) check("r_unexpected", 1, 0);
        else begin
          r_exp_t e;
          e = exp_r.pop_front();
          check("rdata", {96'b0, rdata}, {96'b0, e.data});
          check("rresp", {126'b0, rresp}, {126'b0, e.resp});
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_main_a0);
    #1;
  endtask

  task automatic do_aw(input logic [31:0] a);
    bit hs = 0;
    awaddr  = a;
    awvalid = 1'b1;
    for (int n = 0; n < 50 && !hs; n++) begin
      @(negedge clk_main_a0);
      hs = awready;
      tick(1);
    end
    awvalid = 1'b0;
    if (!hs) check("aw_timeout", 0, 1);
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] s);
    bit hs = 0;
    wdata  = d;
    wstrb  = s;
    wvalid = 1'b1;
    for (int n = 0; n < 50 && !hs; n++) begin
      @(negedge clk_main_a0);
      hs = wready;
      tick(1);
    end
    wvalid = 1'b0;
    if (!hs) check("w_timeout", 0, 1);
  endtask

  task automatic do_ar(input logic [31:0] a);
    bit hs = 0;
    araddr  = a;
    arvalid = 1'b1;
    for (int n = 0; n < 50 && !hs; n++) begin
      @(negedge clk_main_a0);
      hs = arready;
      tick(1);
    end
    arvalid = 1'b0;
    if (!hs) check("ar_timeout", 0, 1);
  endtask

  task automatic wait_b_done();
    bit seen = 0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk_main_a0);
      seen = bvalid && bready;
    end
    tick(1);
    if (!seen) check("b_timeout", 0, 1);
  endtask

  task automatic wait_r_done();
    bit seen = 0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk_main_a0);
      seen = rvalid && rready;
    end
    tick(1);
    if (!seen) check("r_timeout", 0, 1);
  endtask

  // Same-cycle AW+W; returns in the commit cycle.
  task automatic wr_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic [1:0] resp);
    exp_b.push_back(resp);
    fork
      do_aw(a);
      do_w(d, s);
    join
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
    exp_r.push_back('{data: d, resp: resp});
    do_ar(a);
    wait_r_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("reset_rw_q", rw_q, 128'h0);
    check("reset_bvalid_rvalid", {126'b0, bvalid, rvalid}, 0);
    rst_main_n = 1'b1;
    @(negedge clk_main_a0);
    check("reset_readies", {125'b0, awready, wready, arready}, 128'h7);
    check("reset_rdata", {96'b0, rdata}, 0);
    tick(1);

    // Same-cycle AW/W to reg 0, swapped readback
    wr_aw_w(32'h500, 32'h1122_3344, 4'hF, 2'b00);
    check("wr_pulse_r0", {124'b0, wr_pulse}, 128'h1);
    wait_b_done();
    check("wr_pulse_r0_gone", {124'b0, wr_pulse}, 0);
    check("rw_q_r0", {96'b0, rw_q[31:0]}, 128'h1122_3344);
    rd(32'h500, 32'h4433_2211, 2'b00);

    // W three cycles ahead of AW, partial strobe on reg 1
    exp_b.push_back(2'b00);
    do_w(32'hAABB_CCDD, 4'b0101);
    check("w_held_blocks_w", {126'b0, wready, awready}, 128'h1);
    tick(2);
    do_aw(32'h504);
    check("wr_pulse_r1", {124'b0, wr_pulse}, 128'h2);
    wait_b_done();
    check("rw_q_r1", {96'b0, rw_q[63:32]}, 128'h00BB_00DD);
    rd(32'h507, 32'h00BB_00DD, 2'b00);

    // Zero-strobe write still pulses but changes nothing
    wr_aw_w(32'h508, 32'hFFFF_FFFF, 4'h0, 2'b00);
    check("wr_pulse_r2_strb0", {124'b0, wr_pulse}, 128'h4);
    wait_b_done();

    // Unmapped and read-only accesses
    rd(32'h600, 32'hDEAD_BEEF, 2'b10);
    rd(32'h4FC, 32'hDEAD_BEEF, 2'b10);
    rd(32'h518, 32'hDEAD_BEEF, 2'b10);
    wr_aw_w(32'h600, 32'hFFFF_FFFF, 4'hF, 2'b10);
    check("wr_pulse_unmapped", {124'b0, wr_pulse}, 0);
    wait_b_done();
    wr_aw_w(32'h510, 32'hFFFF_FFFF, 4'hF, 2'b00);
    check("wr_pulse_ro", {124'b0, wr_pulse}, 0);
    wait_b_done();
    check("rw_q_untouched", rw_q, {32'h0, 32'h0, 32'h00BB_00DD, 32'h1122_3344});

    // RO slot read with rready held low
    ro_in = {32'h1234_5678, 32'hCAFE_0001};
    rready = 1'b0;
    exp_r.push_back('{data: 32'hCAFE_0001, resp: 2'b00});
    do_ar(32'h510);
    tick(1);
    ro_in[31:0] = 32'hFFFF_0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_main_a0);
      check("r_stall_hold", {95'b0, rvalid, rdata}, {95'b0, 1'b1, 32'hCAFE_0001});
    end
    tick(1);
    rready = 1'b1;
    wait_r_done();
    rd(32'h514, 32'h1234_5678, 2'b00);

    // Read response loading on the same edge as a commit to the same register
    exp_b.push_back(2'b00);
    exp_r.push_back('{data: 32'h00BB_00DD, resp: 2'b00});
    fork
      do_aw(32'h504);
      do_w(32'h5566_7788, 4'hF);
      do_ar(32'h504);
    join
    check("wr_pulse_concurrent", {124'b0, wr_pulse}, 128'h2);
    fork
      wait_b_done();
      wait_r_done();
    join
    rd(32'h504, 32'h5566_7788, 2'b00);

    // B back-pressure blocks the next write
    bready = 1'b0;
    wr_aw_w(32'h50C, 32'h0102_0304, 4'hF, 2'b00);
    tick(1);
    exp_b.push_back(2'b00);
    fork
      begin
        fork
          do_aw(32'h50C);
          do_w(32'hA1B2_C3D4, 4'hF);
        join
      end
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk_main_a0);
          check("b_stall_readies", {125'b0, bvalid, awready, wready}, 128'h4);
          check("b_stall_rw_q_r3", {96'b0, rw_q[127:96]}, 128'h0102_0304);
        end
        tick(1);
        bready = 1'b1;
      end
    join
    wait_b_done();
    check("rw_q_r3_second", {96'b0, rw_q[127:96]}, 128'hA1B2_C3D4);
    rd(32'h50C, 32'hA1B2_C3D4, 2'b00);

    // Reset after AW only; a later lone W must not commit
    do_aw(32'h500);
    rst_main_n = 1'b0;
    #2;
    check("async_reset_rw_q", rw_q, 128'h0);
    tick(2);
    rst_main_n = 1'b1;
    @(negedge clk_main_a0);
    check("post_reset_readies", {125'b0, awready, wready, arready}, 128'h7);
    tick(1);
    do_w(32'h7777_7777, 4'hF);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_main_a0);
      check("no_commit_after_reset", {123'b0, bvalid, wr_pulse}, 0);
    end
    check("regs_after_reset", rw_q, 128'h0);

    check("exp_b_drained", exp_b.size(), 0);
    check("exp_r_drained", exp_r.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
